// File: rtl/arb_mux_n.sv
// N-channel arbiter/multiplexer with a registered, back-pressured output stage.
// Fixed-priority or round-robin grant, selectable per cycle through mode.
module arb_mux_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan_data [N];
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_sel_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  ptr_reg;

  logic             load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = load && grant_any && (grant_idx == SELW'(gi));
    end
  endgenerate

  // The output register can take a word when it is empty or being drained.
  assign load = !out_valid_reg || out_ready;

  // Loops run from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    int t;
    t         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[SELW'(i)]) begin
          grant_any = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        t = int'(ptr_reg) + k;
        if (t >= N) t = t - N;
        if (in_valid[SELW'(t)]) begin
          grant_any = 1'b1;
          grant_idx = SELW'(t);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= SELW'(N - 1);
    end else if (load) begin
      if (grant_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[grant_idx];
        out_sel_reg   <= grant_idx;
        ptr_reg       <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: directed vector table, an N=3 wrap sequence and a
// randomized run checked against a behavioural model of the arbitration rules.
module tb_arb_mux_n;

  localparam int W = 16;
  localparam logic [63:0] DA = 64'h3333_2222_1111_0A0A;
  localparam logic [63:0] DB = 64'h3333_2222_1111_ABCD;

  logic        clk = 1'b0;
  logic        rst, mode, out_ready, out_valid;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;

  logic        rst3, mode3, out_ready3, out_valid3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_sel3;

  int pass_cnt = 0;
  int total_cnt = 0;

  arb_mux_n #(.WIDTH(W), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux_n #(.WIDTH(W), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  valid;
    logic [63:0] data;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [1:0]  exp_sel;
  } tv_t;

  tv_t tab [21];

  // Behavioural model state (N = 4)
  bit          m_valid = 1'b0;
  logic [15:0] m_data = '0;
  int          m_sel = 0;
  int          m_ptr = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  function automatic int model_grant(input bit md, input logic [3:0] v, input int p);
    if (v == 4'b0) return -1;
    if (!md) begin
      for (int i = 0; i < 4; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check combinational ready, clock, check outputs.
  task automatic step(input tv_t row, input bit use_tab);
    bit          ld;
    int          g;
    logic [3:0]  er;
    rst = row.rst; mode = row.mode; in_valid = row.valid;
    in_data = row.data; out_ready = row.oready;
    #1;
    ld = !m_valid || row.oready;
    g  = model_grant(row.mode, row.valid, m_ptr);
    er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 64'(in_ready), use_tab ? 64'(row.exp_ready) : 64'(er));
    @(posedge clk);
    if (row.rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 3;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = row.data[g*16 +: 16]; m_sel = g; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    if (use_tab) begin
      chk("out_valid", 64'(out_valid), 64'(row.exp_valid));
      chk("out_data", 64'(out_data), 64'(row.exp_data));
      chk("out_sel", 64'(out_sel), 64'(row.exp_sel));
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_sel", 64'(out_sel), 64'(m_sel));
    end
  endtask

  initial begin
    tv_t r;
    logic [2:0]  exp3_ready [3];
    logic [1:0]  exp3_sel [3];
    logic [15:0] exp3_data [3];

    rst = 1; mode = 0; in_valid = '0; in_data = '0; out_ready = 1;
    rst3 = 1; mode3 = 1; in_valid3 = '0; in_data3 = {16'h002C, 16'h001B, 16'h000A}; out_ready3 = 1;

    tab[0]  = '{1'b1, 1'b0, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tab[1]  = '{1'b0, 1'b0, 4'b1010, DA, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1};
    tab[2]  = '{1'b0, 1'b0, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 16'h1111, 2'd1};
    tab[3]  = '{1'b1, 1'b0, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tab[4]  = '{1'b0, 1'b1, 4'b1111, DA, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0};
    tab[5]  = '{1'b0, 1'b1, 4'b1111, DA, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1};
    tab[6]  = '{1'b0, 1'b1, 4'b1111, DA, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2};
    tab[7]  = '{1'b0, 1'b1, 4'b1111, DA, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3};
    tab[8]  = '{1'b0, 1'b1, 4'b1111, DA, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0};
    tab[9]  = '{1'b0, 1'b0, 4'b0001, DB, 1'b1, 4'b0001, 1'b1, 16'hABCD, 2'd0};
    tab[10] = '{1'b0, 1'b0, 4'b0001, DA, 1'b0, 4'b0000, 1'b1, 16'hABCD, 2'd0};
    tab[11] = '{1'b0, 1'b0, 4'b0001, DA, 1'b0, 4'b0000, 1'b1, 16'hABCD, 2'd0};
    tab[12] = '{1'b0, 1'b0, 4'b0001, DA, 1'b0, 4'b0000, 1'b1, 16'hABCD, 2'd0};
    tab[13] = '{1'b0, 1'b0, 4'b0001, DA, 1'b1, 4'b0001, 1'b1, 16'h0A0A, 2'd0};
    tab[14] = '{1'b0, 1'b0, 4'b0000, DA, 1'b0, 4'b0000, 1'b1, 16'h0A0A, 2'd0};
    tab[15] = '{1'b1, 1'b0, 4'b0001, DA, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tab[16] = '{1'b1, 1'b1, 4'b0100, DA, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0};
    tab[17] = '{1'b0, 1'b1, 4'b0110, DA, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1};
    tab[18] = '{1'b0, 1'b0, 4'b1100, DA, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd1};
    tab[19] = '{1'b0, 1'b0, 4'b1100, DA, 1'b1, 4'b0100, 1'b1, 16'h2222, 2'd2};
    tab[20] = '{1'b0, 1'b1, 4'b1001, DA, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3};

    for (int i = 0; i < 21; i++) begin
      step(tab[i], 1'b1);
      $display("vec %0d: rst=%0b mode=%0b valid=%b ready=%b -> out_valid=%0b data=%h sel=%0d",
               i, tab[i].rst, tab[i].mode, tab[i].valid, in_ready, out_valid, out_data, out_sel);
    end

    // N=3 round-robin wrap: ptr starts at 2 after reset
    exp3_ready = '{3'b001, 3'b100, 3'b001};
    exp3_sel   = '{2'd0, 2'd2, 2'd0};
    exp3_data  = '{16'h000A, 16'h002C, 16'h000A};
    rst3 = 0; in_valid3 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("n3_in_ready", 64'(in_ready3), 64'(exp3_ready[i]));
      @(posedge clk); #1;
      chk("n3_out_sel", 64'(out_sel3), 64'(exp3_sel[i]));
      chk("n3_out_data", 64'(out_data3), 64'(exp3_data[i]));
      chk("n3_out_valid", 64'(out_valid3), 64'(1'b1));
      $display("n3 xfer %0d: sel=%0d data=%h", i, out_sel3, out_data3);
    end
    in_valid3 = '0;

    // Randomized run against the model; first cycle resets to resync it
    for (int i = 0; i < 2000; i++) begin
      r.rst    = (i == 0) || ($urandom_range(0, 39) == 0);
      r.mode   = 1'($urandom);
      r.valid  = (i == 0) ? 4'b0 : 4'($urandom);
      r.data   = {$urandom, $urandom};
      r.oready = ($urandom_range(0, 3) != 0);
      r.exp_ready = '0; r.exp_valid = 0; r.exp_data = '0; r.exp_sel = '0;
      step(r, 1'b0);
      if (i % 200 == 0)
        $display("rnd %0d: valid=%b ready=%b out_valid=%0b sel=%0d data=%h",
                 i, r.valid, in_ready, out_valid, out_sel, out_data);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each data channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default 2, width of channel index; SHALL equal $clog2(N).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel request, bit i for channel i.
REQ-009 in_ready  output  N  per-channel accept, one-hot or zero, combinational.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_sel  output  SELW  registered index of channel whose data is in out_data.
REQ-012 out_valid  output  1  registered; out_data/out_sel hold a valid transfer.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Internal load = !out_valid || out_ready; output register accepts a new word only when load=1.
REQ-015 Grant vector SHALL be one-hot over channels with in_valid=1, or all-zero if no in_valid bit is set.
REQ-016 mode=0: grant lowest-index channel with in_valid=1.
REQ-017 mode=1: grant first channel with in_valid=1 searching ptr+1, ptr+2, ... wrapping modulo N, ending at ptr.
REQ-018 in_ready[i] = load && grant[i]; transfer on channel i occurs in a cycle where in_valid[i] && in_ready[i].
REQ-019 On a transfer from channel i: next-cycle out_data = in_data[i], out_sel = i, out_valid = 1; latency exactly 1 cycle.
REQ-020 load=1 with no in_valid bit set: out_valid goes 0 next cycle; out_data and out_sel hold previous values.
REQ-021 load=0 (out_valid=1, out_ready=0): out_data, out_sel, out_valid, ptr all hold; in_ready = 0.
REQ-022 ptr (SELW bits) SHALL update to the granted index on every transfer in either mode; otherwise hold.
REQ-023 Wrap: with ptr = N-1 the round-robin search starts at channel 0; indices never exceed N-1 for non-power-of-two N.
REQ-024 Simultaneous out_ready=1 and new transfer: old word consumed and new word loaded in same edge; no bubble, full throughput of one word per cycle.
REQ-025 mode changes take effect combinationally on the current cycle's grant; no state is cleared.
REQ-026 No input data is dropped or duplicated: each accepted word appears on out_data exactly once with out_valid=1 until out_ready=1.

Reset
REQ-027 While rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0, ptr=N-1 on the following cycle.
REQ-028 rst overrides any transfer in the same cycle; a word presented with in_ready=1 during reset is not captured and SHALL NOT be counted as transferred by the bench.
REQ-029 rst asserted mid-stall discards the held word; out_valid=0 after the edge.

Verification
REQ-030 N=4, mode=0, in_valid=4'b1010, data ch1=16'h1111 ch3=16'h3333, out_ready=1 -> in_ready=4'b0010, next cycle out_data=16'h1111, out_sel=1, out_valid=1.
REQ-031 N=4, mode=1, after reset, in_valid=4'b1111 held, out_ready=1 for 5 cycles -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Backpressure: out_valid=1 with word 16'hABCD, out_ready=0 for 3 cycles while in_valid=4'b0001 -> in_ready=0, out_data stays 16'hABCD; out_ready=1 -> next cycle loads channel 0 data.
REQ-033 N=3, mode=1, ptr=2, in_valid=3'b101 -> grant channel 0; then grant channel 2; then channel 0 (wrap, no index 3).
REQ-034 Reset during stall: out_valid=1, out_ready=0, rst=1 one cycle -> out_valid=0, out_data=0, out_sel=0; first round-robin grant after reset goes to lowest valid index.
REQ-035 Empty drain: single transfer then in_valid=0, out_ready=1 -> out_valid=1 one cycle then 0, out_data holds last value.
